// File: rtl/mem_port_arbiter_if.sv
// Memory handshake bundle shared by the engines and the memory port.
// master drives address/strobes/data; slave returns Q/BUSY/DONE.
interface mem_port_arbiter_if #(
  parameter int WA = 32,
  parameter int WD = 32
);
  logic [WA-1:0] A;
  logic          RE;
  logic          WE;
  logic [WD-1:0] D;
  logic [WD-1:0] Q;
  logic          BUSY;
  logic          DONE;

  modport master (output A, RE, WE, D, input Q, BUSY, DONE);
  modport slave  (input A, RE, WE, D, output Q, BUSY, DONE);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two engines.
// Define MEMARB_TIMEOUT_EN to add the WAIT watchdog and the sticky ERR flag.
module mem_port_arbiter #(
  parameter int WA      = 32,
  parameter int WD      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RST_X,
  mem_port_arbiter_if.slave  R0,
  mem_port_arbiter_if.slave  R1,
  mem_port_arbiter_if.master MEM,
  output logic [1:0]         OWNER,
  output logic               ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    owner_reg, owner_next;
  logic          last_reg, last_next;
  logic          prev_last_reg, prev_last_next;
  logic [WA-1:0] mem_a_reg, mem_a_next;
  logic [WD-1:0] mem_d_reg, mem_d_next;
  logic          mem_re_reg, mem_re_next;
  logic          mem_we_reg, mem_we_next;

  logic          req0, req1, grant1, sel1;
  logic          sel_re, sel_we, sel_req;
  logic [WA-1:0] sel_a;
  logic [WD-1:0] sel_d;
  logic          wd_fire;
  logic          own0, own1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign req0   = R0.RE | R0.WE;
  assign req1   = R1.RE | R1.WE;
  // last_reg: 0 = port 0 granted last, 1 = port 1; a tie goes to the other port.
  assign grant1 = req1 & (~req0 | ~last_reg);

  // In IDLE the candidate is the arbitration winner; afterwards it is the owner.
  assign sel1    = (state_reg == S_IDLE) ? grant1 : owner_reg[1];
  assign sel_a   = sel1 ? R1.A  : R0.A;
  assign sel_d   = sel1 ? R1.D  : R0.D;
  assign sel_re  = sel1 ? R1.RE : R0.RE;
  assign sel_we  = sel1 ? R1.WE : R0.WE;
  assign sel_req = sel_re | sel_we;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_reg     <= S_IDLE;
      owner_reg     <= 2'b00;
      last_reg      <= 1'b1;
      prev_last_reg <= 1'b1;
      mem_a_reg     <= '0;
      mem_d_reg     <= '0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      prev_last_reg <= prev_last_next;
      mem_a_reg     <= mem_a_next;
      mem_d_reg     <= mem_d_next;
      mem_re_reg    <= mem_re_next;
      mem_we_reg    <= mem_we_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    prev_last_next = prev_last_reg;
    mem_a_next     = mem_a_reg;
    mem_d_next     = mem_d_reg;
    mem_re_next    = mem_re_reg;
    mem_we_next    = mem_we_reg;
    case (state_reg)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_next     = grant1 ? 2'b10 : 2'b01;
          prev_last_next = last_reg;
          last_next      = grant1;
          mem_a_next     = sel_a;
          mem_d_next     = sel_d;
          mem_re_next    = sel_re & ~sel_we;
          mem_we_next    = sel_we;
          state_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_a_next = sel_a;
        mem_d_next = sel_d;
        if (MEM.BUSY) begin
          mem_re_next = 1'b0;
          mem_we_next = 1'b0;
          state_next  = S_WAIT;
        end else if (!sel_req) begin
          // Abandoned before the memory accepted: undo the grant entirely.
          mem_re_next = 1'b0;
          mem_we_next = 1'b0;
          owner_next  = 2'b00;
          last_next   = prev_last_reg;
          state_next  = S_IDLE;
        end else begin
          mem_re_next = sel_re & ~sel_we;
          mem_we_next = sel_we;
        end
      end
      S_WAIT: begin
        if (MEM.DONE || wd_fire) state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!MEM.BUSY) begin
          owner_next = 2'b00;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_reg, wd_cnt_next;
  logic          err_reg, err_next;

  // Held at zero outside WAIT, so every WAIT entry starts counting from 0.
  always_comb begin
    wd_cnt_next = '0;
    if (state_reg == S_WAIT) wd_cnt_next = wd_cnt_reg + CW'(1);
  end

  assign wd_fire  = (state_reg == S_WAIT) && (wd_cnt_reg == CW'(TIMEOUT)) && !MEM.DONE;
  assign err_next = err_reg | wd_fire;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign ERR = err_reg;
`else
  assign wd_fire = 1'b0;
  assign ERR     = 1'b0;
`endif

  assign own0 = (owner_reg == 2'b01);
  assign own1 = (owner_reg == 2'b10);

  // A watchdog completion reports DONE with zero data.
  assign R0.BUSY = own0 & MEM.BUSY;
  assign R0.DONE = own0 & (MEM.DONE | wd_fire);
  assign R0.Q    = (own0 & ~wd_fire) ? MEM.Q : '0;
  assign R1.BUSY = own1 & MEM.BUSY;
  assign R1.DONE = own1 & (MEM.DONE | wd_fire);
  assign R1.Q    = (own1 & ~wd_fire) ? MEM.Q : '0;

  assign MEM.A  = mem_a_reg;
  assign MEM.D  = mem_d_reg;
  assign MEM.RE = mem_re_reg;
  assign MEM.WE = mem_we_reg;
  assign OWNER  = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; stimulus changes 1 time unit after the
// rising edge, and outputs are read before the next rising edge.
module tb_mem_port_arbiter;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam int TO = 8;

  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic [1:0] OWNER;
  logic       ERR;
  int         checks = 0;
  int         errors = 0;

  mem_port_arbiter_if #(.WA(WA), .WD(WD)) r0_if ();
  mem_port_arbiter_if #(.WA(WA), .WD(WD)) r1_if ();
  mem_port_arbiter_if #(.WA(WA), .WD(WD)) mem_if ();

  mem_port_arbiter #(.WA(WA), .WD(WD), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .R0   (r0_if),
    .R1   (r1_if),
    .MEM  (mem_if),
    .OWNER(OWNER),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    r0_if.A = '0; r0_if.D = '0; r0_if.RE = 1'b0; r0_if.WE = 1'b0;
    r1_if.A = '0; r1_if.D = '0; r1_if.RE = 1'b0; r1_if.WE = 1'b0;
    mem_if.Q = '0; mem_if.BUSY = 1'b0; mem_if.DONE = 1'b0;
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    repeat (2) tick();
    RST_X = 1'b1;
  endtask

  // Memory responder: accept the pending strobe, hold BUSY, answer after two WAIT cycles.
  task automatic mem_serve(input logic [WD-1:0] q, output logic [1:0] who,
                           output logic [WD-1:0] got_q, output logic got_done,
                           output logic leak);
    int n;
    who = 2'b00; got_q = '0; got_done = 1'b0; leak = 1'b0; n = 0;
    while (!(mem_if.RE || mem_if.WE) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!(mem_if.RE || mem_if.WE)) begin
      errors++;
      $display("FAIL serve_grant: no memory strobe within 20 cycles, OWNER=%b", OWNER);
      return;
    end
    who = OWNER;
    mem_if.BUSY = 1'b1;
    #1;
    leak = (who == 2'b01) ? (r1_if.BUSY | r1_if.DONE | (|r1_if.Q))
                          : (r0_if.BUSY | r0_if.DONE | (|r0_if.Q));
    if (who == 2'b01) begin r0_if.RE = 1'b0; r0_if.WE = 1'b0; end
    else begin r1_if.RE = 1'b0; r1_if.WE = 1'b0; end
    tick();
    tick();
    mem_if.DONE = 1'b1;
    mem_if.Q = q;
    #1;
    got_done = (who == 2'b01) ? r0_if.DONE : r1_if.DONE;
    got_q    = (who == 2'b01) ? r0_if.Q : r1_if.Q;
    leak = leak | ((who == 2'b01) ? (r1_if.BUSY | r1_if.DONE | (|r1_if.Q))
                                  : (r0_if.BUSY | r0_if.DONE | (|r0_if.Q)));
    tick();
    mem_if.DONE = 1'b0; mem_if.Q = '0; mem_if.BUSY = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_if.BUSY = 1'b1; mem_if.DONE = 1'b1; mem_if.Q = 32'hABCD;
    do_reset();
    #1;
    checks++;
    if (OWNER !== 2'b00 || ERR !== 1'b0) begin
      errors++; $display("FAIL reset_owner_err: OWNER=%b ERR=%b required 00/0", OWNER, ERR);
    end
    checks++;
    if (mem_if.A !== '0 || mem_if.D !== '0 || mem_if.RE !== 1'b0 || mem_if.WE !== 1'b0) begin
      errors++; $display("FAIL reset_mem: A=%h D=%h RE=%b WE=%b required all 0",
                         mem_if.A, mem_if.D, mem_if.RE, mem_if.WE);
    end
    checks++;
    if ({r0_if.BUSY, r0_if.DONE, r1_if.BUSY, r1_if.DONE} !== 4'b0 || r0_if.Q !== '0 || r1_if.Q !== '0) begin
      errors++; $display("FAIL reset_ports: R0 B/D/Q=%b/%b/%h R1 B/D/Q=%b/%b/%h required 0",
                         r0_if.BUSY, r0_if.DONE, r0_if.Q, r1_if.BUSY, r1_if.DONE, r1_if.Q);
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    clear_inputs(); do_reset();
    r0_if.A = 32'h40; r0_if.RE = 1'b1;
    #1;
    checks++;
    if (mem_if.RE !== 1'b0) begin
      errors++; $display("FAIL read_early: MEM_RE=%b required 0 before grant edge", mem_if.RE);
    end
    tick();
    checks++;
    if (mem_if.RE !== 1'b1 || mem_if.WE !== 1'b0 || mem_if.A !== 32'h40 || OWNER !== 2'b01) begin
      errors++; $display("FAIL read_grant: RE=%b WE=%b A=%h OWNER=%b required 1/0/40/01",
                         mem_if.RE, mem_if.WE, mem_if.A, OWNER);
    end
    tick();
    mem_if.BUSY = 1'b1;
    #1;
    checks++;
    if (r0_if.BUSY !== 1'b1 || r1_if.BUSY !== 1'b0) begin
      errors++; $display("FAIL read_busy: R0_BUSY=%b R1_BUSY=%b required 1/0", r0_if.BUSY, r1_if.BUSY);
    end
    r0_if.RE = 1'b0;
    tick();
    checks++;
    if (mem_if.RE !== 1'b0 || OWNER !== 2'b01) begin
      errors++; $display("FAIL read_wait: MEM_RE=%b OWNER=%b required 0/01", mem_if.RE, OWNER);
    end
    tick(); tick();
    mem_if.DONE = 1'b1; mem_if.Q = 32'h1234;
    #1;
    checks++;
    if (r0_if.DONE !== 1'b1 || r0_if.Q !== 32'h1234) begin
      errors++; $display("FAIL read_done: R0_DONE=%b R0_Q=%h required 1/1234", r0_if.DONE, r0_if.Q);
    end
    checks++;
    if (r1_if.DONE !== 1'b0 || r1_if.Q !== '0) begin
      errors++; $display("FAIL read_r1_quiet: R1_DONE=%b R1_Q=%h required 0/0", r1_if.DONE, r1_if.Q);
    end
    tick();
    mem_if.DONE = 1'b0; mem_if.Q = '0; mem_if.BUSY = 1'b0;
    tick();
    checks++;
    if (OWNER !== 2'b00) begin
      errors++; $display("FAIL read_release: OWNER=%b required 00", OWNER);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] who; logic [WD-1:0] q; logic dn, leak;
    clear_inputs(); do_reset();
    r0_if.A = 32'h10; r0_if.RE = 1'b1;
    r1_if.A = 32'h20; r1_if.RE = 1'b1;
    mem_serve(32'h0A0A, who, q, dn, leak);
    checks++;
    if (who !== 2'b01 || q !== 32'h0A0A || dn !== 1'b1 || leak !== 1'b0) begin
      errors++; $display("FAIL tie_first: owner=%b q=%h done=%b leak=%b required 01/0a0a/1/0", who, q, dn, leak);
    end
    mem_serve(32'h0B0B, who, q, dn, leak);
    checks++;
    if (who !== 2'b10 || q !== 32'h0B0B || dn !== 1'b1 || leak !== 1'b0) begin
      errors++; $display("FAIL tie_second: owner=%b q=%h done=%b leak=%b required 10/0b0b/1/0", who, q, dn, leak);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] who, exp; logic [WD-1:0] q; logic dn, leak;
    int left0, left1;
    clear_inputs(); do_reset();
    r0_if.RE = 1'b1; r1_if.RE = 1'b1;
    left0 = 3; left1 = 3;
    for (int k = 0; k < 8; k++) begin
      mem_serve(WD'(k), who, q, dn, leak);
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (who !== exp) begin
        errors++; $display("FAIL alternate_%0d: owner=%b required %b", k, who, exp);
      end
      if (who == 2'b01 && left0 > 0) begin r0_if.RE = 1'b1; left0--; end
      if (who == 2'b10 && left1 > 0) begin r1_if.RE = 1'b1; left1--; end
    end
  endtask

  task automatic test_write_precedence();
    logic [1:0] who; logic [WD-1:0] q; logic dn, leak;
    clear_inputs(); do_reset();
    r1_if.A = 32'h80; r1_if.D = 32'hDEAD; r1_if.RE = 1'b1; r1_if.WE = 1'b1;
    tick();
    checks++;
    if (mem_if.WE !== 1'b1 || mem_if.RE !== 1'b0 || mem_if.D !== 32'hDEAD || OWNER !== 2'b10) begin
      errors++; $display("FAIL write_prec: WE=%b RE=%b D=%h OWNER=%b required 1/0/dead/10",
                         mem_if.WE, mem_if.RE, mem_if.D, OWNER);
    end
    mem_serve('0, who, q, dn, leak);
  endtask

  task automatic test_abandon();
    clear_inputs(); do_reset();
    r0_if.RE = 1'b1;
    tick();
    checks++;
    if (OWNER !== 2'b01) begin
      errors++; $display("FAIL abandon_grant: OWNER=%b required 01", OWNER);
    end
    r0_if.RE = 1'b0;
    tick();
    checks++;
    if (OWNER !== 2'b00 || mem_if.RE !== 1'b0) begin
      errors++; $display("FAIL abandon_drop: OWNER=%b MEM_RE=%b required 00/0", OWNER, mem_if.RE);
    end
    r0_if.RE = 1'b1; r1_if.RE = 1'b1;
    tick();
    checks++;
    if (OWNER !== 2'b01) begin
      errors++; $display("FAIL abandon_last_restored: OWNER=%b required 01", OWNER);
    end
  endtask

  task automatic test_reset_in_wait();
    clear_inputs(); do_reset();
    r0_if.RE = 1'b1;
    tick();
    mem_if.BUSY = 1'b1; r0_if.RE = 1'b0;
    tick();
    RST_X = 1'b0;
    #1;
    checks++;
    if (OWNER !== 2'b00 || mem_if.RE !== 1'b0 || r0_if.BUSY !== 1'b0) begin
      errors++; $display("FAIL async_reset: OWNER=%b MEM_RE=%b R0_BUSY=%b required 00/0/0",
                         OWNER, mem_if.RE, r0_if.BUSY);
    end
    tick();
    RST_X = 1'b1;
    mem_if.DONE = 1'b1; mem_if.Q = 32'h5555;
    #1;
    checks++;
    if (r0_if.DONE !== 1'b0 || r1_if.DONE !== 1'b0 || r0_if.Q !== '0) begin
      errors++; $display("FAIL stray_done: R0_DONE=%b R1_DONE=%b R0_Q=%h required 0/0/0",
                         r0_if.DONE, r1_if.DONE, r0_if.Q);
    end
    tick();
    checks++;
    if (OWNER !== 2'b00) begin
      errors++; $display("FAIL stray_done_idle: OWNER=%b required 00", OWNER);
    end
    mem_if.DONE = 1'b0; mem_if.Q = '0; mem_if.BUSY = 1'b0;
    r0_if.RE = 1'b1; r1_if.RE = 1'b1;
    tick();
    checks++;
    if (OWNER !== 2'b01) begin
      errors++; $display("FAIL post_reset_grant: OWNER=%b required 01", OWNER);
    end
  endtask

  task automatic test_timeout();
    clear_inputs(); do_reset();
    r0_if.RE = 1'b1;
    tick();
    mem_if.BUSY = 1'b1; mem_if.Q = 32'hFFFF; r0_if.RE = 1'b0;
    tick();
    repeat (TO - 1) tick();
`ifdef MEMARB_TIMEOUT_EN
    checks++;
    if (r0_if.DONE !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL wd_early: R0_DONE=%b ERR=%b in WAIT cycle 8 required 0/0", r0_if.DONE, ERR);
    end
    tick();
    checks++;
    if (r0_if.DONE !== 1'b1 || r0_if.Q !== '0) begin
      errors++; $display("FAIL wd_pulse: R0_DONE=%b R0_Q=%h in WAIT cycle 9 required 1/0", r0_if.DONE, r0_if.Q);
    end
    tick();
    checks++;
    if (ERR !== 1'b1 || r0_if.DONE !== 1'b0 || OWNER !== 2'b01) begin
      errors++; $display("FAIL wd_release: ERR=%b R0_DONE=%b OWNER=%b required 1/0/01", ERR, r0_if.DONE, OWNER);
    end
    mem_if.BUSY = 1'b0;
    tick();
    tick();
    checks++;
    if (OWNER !== 2'b00 || ERR !== 1'b1) begin
      errors++; $display("FAIL wd_sticky: OWNER=%b ERR=%b required 00/1", OWNER, ERR);
    end
`else
    repeat (4) tick();
    checks++;
    if (r0_if.DONE !== 1'b0 || ERR !== 1'b0 || OWNER !== 2'b01) begin
      errors++; $display("FAIL no_watchdog: R0_DONE=%b ERR=%b OWNER=%b required 0/0/01", r0_if.DONE, ERR, OWNER);
    end
    mem_if.DONE = 1'b1;
    tick();
    mem_if.DONE = 1'b0; mem_if.BUSY = 1'b0;
    tick();
    checks++;
    if (OWNER !== 2'b00 || ERR !== 1'b0) begin
      errors++; $display("FAIL late_done_release: OWNER=%b ERR=%b required 00/0", OWNER, ERR);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_alternation();
    test_write_precedence();
    test_abandon();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
